// File: rtl/phy_lane_serializer.sv
`default_nettype none
// ============================================================================
// Module      : phy_lane_serializer
// Description : Multi-lane PHY transmit serializer. Buffers parallel flits in a
//               small FIFO and shifts each lane out LSB first, one bit per lane
//               per clock. It can also emit per-lane PRBS7 or stay idle.
// Ports       : clock          - single rising-edge clock
//               reset          - asynchronous active-low reset
//               io_mode        - 0=DATA, 1=PRBS, 2/3=IDLE (sampled per flit)
//               io_in_valid    - flit offered
//               io_in_ready    - FIFO has room (combinational)
//               io_in_bits     - flit, lane i at [i*LANE_W +: LANE_W]
//               io_out_data    - one serial bit per lane
//               io_out_valid   - io_out_data carries a symbol bit
//               io_out_frame   - marks bit 0 of each flit
//               io_fifo_count  - FIFO occupancy
//               io_sent_count  - DATA flits fully sent (wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
module phy_lane_serializer #(
    parameter int NUM_LANES = 16,
    parameter int LANE_W    = 8,
    parameter int DEPTH     = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [1:0]                    io_mode,
    input  logic                          io_in_valid,
    output logic                          io_in_ready,
    input  logic [NUM_LANES*LANE_W-1:0]   io_in_bits,
    output logic [NUM_LANES-1:0]          io_out_data,
    output logic                          io_out_valid,
    output logic                          io_out_frame,
    output logic [$clog2(DEPTH+1)-1:0]    io_fifo_count,
    output logic [15:0]                   io_sent_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = (LANE_W > 1) ? $clog2(LANE_W) : 1;

    localparam logic [CW-1:0] c_depthCnt = CW'(DEPTH);
    localparam logic [IW-1:0] c_lastIdx  = IW'(LANE_W - 1);
    localparam logic [1:0]    c_modeData = 2'd0;
    localparam logic [1:0]    c_modePrbs = 2'd1;

    typedef logic [NUM_LANES-1:0][LANE_W-1:0] flit_t;
    typedef logic [NUM_LANES-1:0][6:0]        lfsrVec_t;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    // Per-lane PRBS7 seed: (lane mod 127) + 1, never the all-zero lock-up state.
    function automatic logic [6:0] seedOf(input int lane);
        return 7'((lane % 127) + 1);
    endfunction

    function automatic logic [6:0] lfsrStep(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

    // ---------------------------------------------------------------- state
    flit_t                r_mem [DEPTH];
    logic [PW-1:0]        r_wrPtr;
    logic [PW-1:0]        r_rdPtr;
    logic [CW-1:0]        r_count;
    state_t               r_state;
    logic [IW-1:0]        r_idx;
    flit_t                r_shift;
    logic                 r_isPrbs;
    lfsrVec_t             r_lfsr;
    logic [NUM_LANES-1:0] r_outData;
    logic                 r_outValid;
    logic                 r_outFrame;
    logic [15:0]          r_sentCount;

    // ------------------------------------------------------------ next-state
    logic                 w_push;
    logic                 w_pop;
    logic                 w_boundary;
    state_t               w_stateNext;
    logic [IW-1:0]        w_idxNext;
    flit_t                w_shiftNext;
    logic                 w_isPrbsNext;
    lfsrVec_t             w_lfsrNext;
    logic [NUM_LANES-1:0] w_outDataNext;
    logic                 w_outValidNext;
    logic                 w_outFrameNext;
    logic                 w_sentInc;
    flit_t                w_head;
    logic [6:0]           w_lfsrCur;

    // Ready is gated by reset so nothing is offered acceptance while held.
    assign io_in_ready = reset && (r_count < c_depthCnt);
    assign w_push      = io_in_valid && io_in_ready;
    assign w_head      = r_mem[r_rdPtr];

    always_comb begin
        w_stateNext    = r_state;
        w_idxNext      = r_idx;
        w_pop          = 1'b0;
        w_shiftNext    = r_shift;
        w_isPrbsNext   = r_isPrbs;
        w_lfsrNext     = r_lfsr;
        w_outDataNext  = '0;
        w_outValidNext = 1'b0;
        w_outFrameNext = 1'b0;
        w_sentInc      = 1'b0;
        w_lfsrCur      = '0;
        w_boundary     = (r_state == S_IDLE) || (r_idx == c_lastIdx);

        if (w_boundary) begin
            // Mode is only looked at here, so a flit in flight always completes.
            w_idxNext = '0;
            if ((io_mode == c_modeData) && (r_count != '0)) begin
                w_pop          = 1'b1;
                w_shiftNext    = w_head;
                w_stateNext    = S_SHIFT;
                w_isPrbsNext   = 1'b0;
                w_outValidNext = 1'b1;
                w_outFrameNext = 1'b1;
                for (int i = 0; i < NUM_LANES; i++) begin
                    w_outDataNext[i] = w_head[i][0];
                end
            end else if (io_mode == c_modePrbs) begin
                w_stateNext    = S_SHIFT;
                w_isPrbsNext   = 1'b1;
                w_outValidNext = 1'b1;
                w_outFrameNext = 1'b1;
                for (int i = 0; i < NUM_LANES; i++) begin
                    // Continue the sequence across back-to-back PRBS flits;
                    // restart from the seed on any fresh entry.
                    w_lfsrCur        = (r_state == S_SHIFT && r_isPrbs) ? r_lfsr[i] : seedOf(i);
                    w_outDataNext[i] = w_lfsrCur[6];
                    w_lfsrNext[i]    = lfsrStep(w_lfsrCur);
                end
            end else begin
                w_stateNext  = S_IDLE;
                w_isPrbsNext = 1'b0;
            end
        end else begin
            w_idxNext      = r_idx + IW'(1);
            w_outValidNext = 1'b1;
            if (r_isPrbs) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    w_outDataNext[i] = r_lfsr[i][6];
                    w_lfsrNext[i]    = lfsrStep(r_lfsr[i]);
                end
            end else begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    w_outDataNext[i] = r_shift[i][w_idxNext];
                end
                // Counted on the edge that puts the final bit on the wire.
                w_sentInc = (w_idxNext == c_lastIdx);
            end
        end
    end

    // --------------------------------------------------------------- registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < DEPTH; d++) begin
                r_mem[d] <= '0;
            end
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_shift     <= '0;
            r_isPrbs    <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                r_lfsr[i] <= seedOf(i);
            end
            r_outData   <= '0;
            r_outValid  <= 1'b0;
            r_outFrame  <= 1'b0;
            r_sentCount <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= io_in_bits;
                r_wrPtr        <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_state    <= w_stateNext;
            r_idx      <= w_idxNext;
            r_shift    <= w_shiftNext;
            r_isPrbs   <= w_isPrbsNext;
            r_lfsr     <= w_lfsrNext;
            r_outData  <= w_outDataNext;
            r_outValid <= w_outValidNext;
            r_outFrame <= w_outFrameNext;
            if (w_sentInc) begin
                r_sentCount <= r_sentCount + 16'd1;
            end
        end
    end

    assign io_out_data   = r_outData;
    assign io_out_valid  = r_outValid;
    assign io_out_frame  = r_outFrame;
    assign io_fifo_count = r_count;
    assign io_sent_count = r_sentCount;

endmodule
`default_nettype wire

// File: doc/phy_lane_serializer.md
PHY_LANE_SERIALIZER -- requirements
Module: phy_lane_serializer

Interface
REQ-001 The block SHALL have parameter NUM_LANES, default 16, giving the number of physical lanes.
REQ-002 The block SHALL have parameter LANE_W, default 8, giving the bits per lane per flit; legal values are 2 or more.
REQ-003 The block SHALL have parameter DEPTH, default 4, giving flit FIFO entries; legal values are powers of 2, 2 or more.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port io_mode, input, 2 bits: 0=DATA, 1=PRBS, 2 or 3=IDLE.
REQ-007 The block SHALL have port io_in_valid, input, 1 bit: a flit is offered.
REQ-008 The block SHALL have port io_in_ready, output, 1 bit: the FIFO can accept a flit.
REQ-009 The block SHALL have port io_in_bits, input, NUM_LANES*LANE_W bits; lane i is bits [i*LANE_W +: LANE_W].
REQ-010 The block SHALL have port io_out_data, output, NUM_LANES bits: one serial bit per lane per cycle.
REQ-011 The block SHALL have port io_out_valid, output, 1 bit: io_out_data carries a symbol bit.
REQ-012 The block SHALL have port io_out_frame, output, 1 bit: marks bit 0 of each flit.
REQ-013 The block SHALL have port io_fifo_count, output, clog2(DEPTH+1) bits: current FIFO occupancy.
REQ-014 The block SHALL have port io_sent_count, output, 16 bits: number of DATA flits fully sent, wrapping.

Function
REQ-015 io_in_ready SHALL be (count < DEPTH), independent of io_in_valid; a push SHALL occur when io_in_valid && io_in_ready.
REQ-016 A simultaneous push and pop SHALL leave the count unchanged; when the FIFO is full, no push SHALL occur; when it is empty, no pop SHALL occur.
REQ-017 The serializer SHALL have two states, IDLE and SHIFT, plus a bit index idx counting 0..LANE_W-1.
REQ-018 Mode SHALL be sampled only at a flit boundary (IDLE, or SHIFT with idx==LANE_W-1); a flit in progress SHALL always complete.
REQ-019 IDLE->SHIFT: at the boundary, in DATA mode with count>0, the block SHALL pop the FIFO head into the shift register and set idx=0.
REQ-020 IDLE->SHIFT: at the boundary, in PRBS mode, the block SHALL load the per-lane LFSRs and set idx=0; the FIFO SHALL NOT be popped.
REQ-021 In SHIFT, io_out_data[i] SHALL equal bit idx (LSB first) of lane i, io_out_valid SHALL be 1, and io_out_frame SHALL be (idx==0).
REQ-022 At idx==LANE_W-1 the block SHALL re-evaluate per REQ-019/020 and continue back-to-back with no bubble if a flit is available; otherwise it SHALL go to IDLE.
REQ-023 Latency: for a push accepted at edge k into an empty FIFO in DATA mode, bit j SHALL be visible after edge k+1+j.
REQ-024 All outputs except io_in_ready SHALL be registered.
REQ-025 PRBS: each lane SHALL use a 7-bit LFSR with seed (i mod 127)+1, output = lfsr[6], next = {lfsr[5:0], lfsr[6]^lfsr[5]}.
REQ-026 The LFSRs SHALL advance only while emitting in PRBS mode and SHALL reseed on each entry into PRBS mode.
REQ-027 In IDLE state, io_out_data, io_out_valid and io_out_frame SHALL be 0.
REQ-028 io_sent_count SHALL increment when the last bit of a DATA flit is emitted; PRBS symbols SHALL NOT count; 16'hFFFF SHALL wrap to 0.
REQ-029 Pushes SHALL continue in any mode; FIFO contents SHALL be retained across mode changes.

Reset
REQ-030 While reset is low, all registers SHALL clear immediately: FIFO empty, state IDLE, idx=0, io_out_*=0, io_fifo_count=0, io_sent_count=0, LFSRs at seed.
REQ-031 io_in_ready SHALL be 0 while reset is low.
REQ-032 A reset asserted mid-flit SHALL abort the flit and discard FIFO contents.

Verification
REQ-033 Single flit (defaults, DATA mode), lane i = i+1 -> 8 valid cycles, frame in cycle 0 only, cycle 0 io_out_data=16'h5555, cycle 4 io_out_data=16'h8000, io_sent_count=1.
REQ-034 Four consecutive flits with values 1..4 on all lanes -> 32 contiguous valid cycles, frame at cycles 0/8/16/24, io_sent_count=4, io_fifo_count returns to 0.
REQ-035 IDLE mode with io_in_valid held -> 4 flits accepted, io_in_ready=0, io_fifo_count=4, io_out_valid=0; then switch to DATA -> FIFO drains in 32 cycles and io_in_ready rises after the first pop.
REQ-036 Switch DATA->IDLE at idx=3 with 2 flits queued -> bits 4..7 still sent, then io_out_valid=0, io_fifo_count=2.
REQ-037 PRBS mode -> lane 0 emits 0,0,0,0,0,0,1 over the first 7 cycles, io_fifo_count unchanged, io_sent_count unchanged.
REQ-038 reset low at idx=4 with 2 flits queued -> all outputs 0 in the same cycle; after release io_fifo_count=0, io_sent_count=0, io_in_ready=1.
